// File: rtl/button_pkg.sv
// Shared constants for the push-button front end: channel map, default clock
// and the millisecond-to-cycle conversion used to size debounce/long timers.
package button_pkg;

  localparam int BTN_JUGAR      = 0;
  localparam int BTN_ALIMENTAR  = 1;
  localparam int BTN_CURAR      = 2;
  localparam int BTN_ACELERAR   = 3;

  localparam int CLK_HZ_DEFAULT = 50_000_000;

  // Cycles spanned by ms milliseconds at clk_hz; divide first to stay inside 32 bits.
  function automatic int ms_to_cycles(input int clk_hz, input int ms);
    return (clk_hz / 32'sd1000) * ms;
  endfunction

endpackage

// File: rtl/button_conditioner_if.sv
// Bundle of raw pads and conditioned button events; master drives the pads,
// slave (the conditioner) produces the clean level and pulses.
interface button_conditioner_if #(
  parameter int N_BTN = 4
);

  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_press;
  logic [N_BTN-1:0] btn_release;
  logic [N_BTN-1:0] btn_long;
  logic [N_BTN-1:0] btn_held_long;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  btn_long,
    input  btn_held_long
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release,
    output btn_long,
    output btn_held_long
  );

endinterface

// File: rtl/button_channel.sv
// One button: two-flop synchroniser, debounce counter, long-press timer and
// registered level/press/release/long outputs.
module button_channel #(
  parameter int DB_CYC     = 4,
  parameter int LONG_CYC   = 10,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_neg,
  input  logic raw,
  output logic level,
  output logic press_evt,
  output logic release_evt,
  output logic long_evt,
  output logic held_long
);

  localparam int DB_W   = $clog2(DB_CYC);
  localparam int LONG_W = $clog2(LONG_CYC);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYC - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYC - 1);

  logic              pad_s;
  logic              sync1_r;
  logic              sync2_r;
  logic              stable_r;
  logic [DB_W-1:0]   db_cnt_r;
  logic [LONG_W-1:0] long_cnt_r;
  logic              level_r;
  logic              press_r;
  logic              release_r;
  logic              long_r;
  logic              held_r;

  // Normalise pad polarity so that 1 means pressed from here on.
  always_comb begin
    pad_s = (ACTIVE_LOW != 0) ? ~raw : raw;
  end

  // Two-flop synchroniser; reset loads the released state.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= pad_s;
      sync2_r <= sync1_r;
    end
  end

  // Debounce: accept a new level only after DB_CYC consecutive disagreeing samples.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      stable_r <= 1'b0;
      db_cnt_r <= {DB_W{1'b0}};
    end else if (sync2_r == stable_r) begin
      db_cnt_r <= {DB_W{1'b0}};
    end else if (db_cnt_r == DB_LAST) begin
      stable_r <= ~stable_r;
      db_cnt_r <= {DB_W{1'b0}};
    end else begin
      db_cnt_r <= db_cnt_r + DB_W'(1);
    end
  end

  // Hold timer: counts while the published level is high and saturates at the last value.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      long_cnt_r <= {LONG_W{1'b0}};
    end else if (!level_r) begin
      long_cnt_r <= {LONG_W{1'b0}};
    end else if (long_cnt_r != LONG_LAST) begin
      long_cnt_r <= long_cnt_r + LONG_W'(1);
    end else begin
      long_cnt_r <= long_cnt_r;
    end
  end

  // Registered outputs; stable_r leads level_r by one cycle, giving the edge pulses
  // and letting held_long drop in the same cycle as the release pulse.
  always_ff @(posedge clk or negedge rst_neg) begin
    if (!rst_neg) begin
      level_r   <= 1'b0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      held_r    <= 1'b0;
    end else begin
      level_r   <= stable_r;
      press_r   <= stable_r & ~level_r;
      release_r <= ~stable_r & level_r;
      long_r    <= stable_r & level_r & (long_cnt_r == LONG_LAST) & ~held_r;
      held_r    <= stable_r & (held_r | (level_r & (long_cnt_r == LONG_LAST)));
    end
  end

  assign level       = level_r;
  assign press_evt   = press_r;
  assign release_evt = release_r;
  assign long_evt    = long_r;
  assign held_long   = held_r;

endmodule

// File: rtl/button_conditioner.sv
// Conditions every board push-button independently for the control FSM:
// one button_channel per pad, nothing else at this level.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN       = 4,
  parameter int CLK_HZ      = CLK_HZ_DEFAULT,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 5000,
  parameter int ACTIVE_LOW  = 1
) (
  input logic                 clk,
  input logic                 rst_neg,
  button_conditioner_if.slave bus
);

  localparam int DB_CYC   = ms_to_cycles(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cycles(CLK_HZ, LONG_MS);

  logic [N_BTN-1:0] level_s;
  logic [N_BTN-1:0] press_s;
  logic [N_BTN-1:0] release_s;
  logic [N_BTN-1:0] long_s;
  logic [N_BTN-1:0] held_s;

  for (genvar i = 0; i < N_BTN; i++) begin : g_chan
    button_channel #(
      .DB_CYC     (DB_CYC),
      .LONG_CYC   (LONG_CYC),
      .ACTIVE_LOW (ACTIVE_LOW)
    ) u_chan (
      .clk         (clk),
      .rst_neg     (rst_neg),
      .raw         (bus.btn_raw[i]),
      .level       (level_s[i]),
      .press_evt   (press_s[i]),
      .release_evt (release_s[i]),
      .long_evt    (long_s[i]),
      .held_long   (held_s[i])
    );
  end

  assign bus.btn_level     = level_s;
  assign bus.btn_press     = press_s;
  assign bus.btn_release   = release_s;
  assign bus.btn_long      = long_s;
  assign bus.btn_held_long = held_s;

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage between the board push-buttons (jugar, alimentar, curar, acelerar) and the main control FSM.
- Per channel: synchronises the raw pad, debounces it, and produces a clean level, one-cycle press/release pulses and a long-press indication.
- The control FSM consumes these outputs instead of raw pads, so a bounce counts as one action and a hold can drive "fast" mode or test mode.

Parameters:
- N_BTN, 4, number of button channels.
- CLK_HZ, 50_000_000, clock frequency in Hz.
- DEBOUNCE_MS, 20, stable time required to accept a level change.
- LONG_MS, 5000, hold time after which a press counts as long.
- ACTIVE_LOW, 1, 1 = raw pad reads 0 when pressed.

Ports:
- clk  in  1  system clock.
- rst_neg  in  1  reset, asynchronous, active-low.
- btn_raw  in  N_BTN  raw asynchronous button pads.
- btn_level  out  N_BTN  debounced level, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse on accepted press.
- btn_release  out  N_BTN  one-cycle pulse on accepted release.
- btn_long  out  N_BTN  one-cycle pulse when hold reaches LONG_MS.
- btn_held_long  out  N_BTN  level, 1 from the btn_long cycle until the accepted release.

Behaviour:
- Derived constants:
  - DB_CYC = CLK_HZ/1000*DEBOUNCE_MS.
  - LONG_CYC = CLK_HZ/1000*LONG_MS.
  - Counter widths = $clog2 of each value.
  - Both values must be at least 2.
- Reset (rst_neg=0, async): sync flops load the inactive pad value. Every output, stable state and counter is 0. Outputs drop in the same instant reset asserts.
- Polarity: the pad is inverted when ACTIVE_LOW=1 before the first sync flop. Internally, 1 = pressed.
- Sync: two-flop synchroniser per channel. No other logic on the raw path.
- Debounce, per channel:
  - If sync output ≠ stable: db_cnt increments.
  - If they are equal: db_cnt clears to 0.
  - When db_cnt = DB_CYC-1 and they still differ: stable toggles and db_cnt clears.
  - Any glitch shorter than DB_CYC cycles gives no output change.
- Latency: for a clean raw edge sampled at edge k, stable changes at edge k+2+DB_CYC. All outputs are registered and update in that same cycle. Total latency is exactly DB_CYC+2 cycles.
- btn_level = stable.
- btn_press is 1 for exactly the one cycle in which stable goes 0→1. btn_release is 1 for exactly the one cycle in which stable goes 1→0.
- Long press:
  - long_cnt runs while stable=1 and clears while stable=0.
  - When long_cnt reaches LONG_CYC-1: btn_long pulses once and btn_held_long sets.
  - long_cnt then saturates, so there is no second pulse during the same hold.
  - On release: btn_held_long clears in the btn_release cycle.
- Channels are fully independent. Simultaneous presses on several channels give simultaneous pulses.
- Reset mid-hold: after reset, a button still held must be stable for a full DB_CYC before btn_level rises. btn_press is then generated normally, and the long timer restarts from 0.
- btn_press and btn_long can never be high in the same cycle, because LONG_CYC ≥ 2.

Decomposition:
- Shared package button_pkg:
  - Channel index constants BTN_JUGAR=0, BTN_ALIMENTAR=1, BTN_CURAR=2, BTN_ACELERAR=3.
  - Default CLK_HZ.
  - A constant function computing cycles from milliseconds.
- Sub-module button_channel:
  - Contains the sync, debounce counter, long counter and edge/pulse logic for one channel.
  - button_conditioner instantiates it N_BTN times in a generate loop. The top level holds no other logic.

Test Plan:
- All tests use bench parameters CLK_HZ=1000, DEBOUNCE_MS=4, LONG_MS=10, so DB_CYC=4 and LONG_CYC=10.
- Clean press: raw (active-low) 1→0 sampled at edge 10 and held → btn_level rises at edge 16, btn_press high only in cycle 16, other channels stay 0.
- Bounce rejection: raw toggles every 2 cycles for 20 cycles, then held pressed → exactly one btn_press, 6 cycles after the last toggle. btn_level never pulses during the bounce.
- Long press: hold 30 cycles → btn_long is one pulse 10 cycles after btn_press, btn_held_long rises with it and stays 1. On release, btn_release pulses and btn_held_long clears in the same cycle.
- Short press: hold 7 cycles then release → btn_press and btn_release are 7 cycles apart, btn_long never asserts.
- Simultaneous: channels 0 and 3 pressed at the same edge → identical-cycle btn_press[0] and btn_press[3].
- Reset mid-hold: drop rst_neg for 3 cycles while btn_held_long=1 → all outputs 0 immediately. After release of reset with the button still held: btn_press exactly 6 cycles later, btn_long 10 cycles after that.
